bus_master_ctrl: RTL

Single-master bus front-end that sits directly upstream of the bus arbiter and consumes its grant. It accepts a burst command (read or write, base address, word count) over a valid/ready handshake. It raises m_req to the arbiter, waits for m_grant, then issues one bus beat per granted cycle with incrementing addresses. It releases the request when the burst completes.

---
 rtl/bus_master_ctrl.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/bus_master_ctrl.sv
// Bus master front-end: takes a burst command over valid/ready, requests the
// bus from the arbiter, issues one beat per granted cycle with incrementing
// addresses, and returns read data through a two-stage registered path.
//
// state  | meaning
// IDLE   | ready for a command, no bus request
// REQ    | request raised, waiting for the first grant
// XFER   | one beat per granted cycle, stall while grant is low
// RDLAST | request dropped, capturing the final read word
// DONE   | one-cycle completion pulse
module bus_master_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_wr,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DATA_W-1:0] wdata,
    output logic              wdata_pop,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              done,
    output logic              busy,
    output logic              m_req,
    input  logic              m_grant,
    output logic              m_en,
    output logic              m_wr,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_dout,
    input  logic [DATA_W-1:0] m_din
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_XFER,
        S_RDLAST,
        S_DONE
    } state_t;

    state_t state, next_state;

    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  beat_q;
    logic              rd_pend;
    logic              last_beat;

    assign last_beat = (beat_q == len_q - LEN_W'(1));

    // State register; reset abandons any burst in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    next_state = (cmd_len == '0) ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                if (m_grant) begin
                    next_state = S_XFER;
                end
            end
            S_XFER: begin
                if (m_grant && last_beat) begin
                    next_state = wr_q ? S_DONE : S_RDLAST;
                end
            end
            S_RDLAST: next_state = S_DONE;
            S_DONE:   next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    // Bus-side outputs, combinational from state, beat counter and grant.
    always_comb begin
        cmd_ready = (state == S_IDLE);
        busy      = (state != S_IDLE);
        m_req     = (state == S_REQ) || (state == S_XFER);
        m_en      = (state == S_XFER) && m_grant;
        m_wr      = m_en && wr_q;
        wdata_pop = m_en && wr_q;
        m_addr    = '0;
        m_dout    = '0;
        if (m_en) begin
            m_addr = addr_q + ADDR_W'(beat_q);
        end
        if (m_en && wr_q) begin
            m_dout = wdata;
        end
    end

    // Command latch on acceptance; beat counter advances on every issued beat.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_q   <= 1'b0;
            addr_q <= '0;
            len_q  <= '0;
            beat_q <= '0;
        end else if (state == S_IDLE && cmd_valid) begin
            wr_q   <= cmd_wr;
            addr_q <= cmd_addr;
            len_q  <= cmd_len;
            beat_q <= '0;
        end else if (m_en) begin
            beat_q <= beat_q + LEN_W'(1);
        end
    end

    // Read return: slave data arrives the cycle after the beat and is
    // registered one more time, so rdata_valid trails m_en by two cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_pend     <= 1'b0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            done        <= 1'b0;
        end else begin
            rd_pend     <= m_en && !wr_q;
            rdata_valid <= rd_pend;
            if (rd_pend) begin
                rdata <= m_din;
            end
            done <= (next_state == S_DONE);
        end
    end

endmodule
